// File: rtl/cross_bar_pkg.sv
// Shared definitions for the N-master x M-slave req/ack crossbar.
// Provides command encodings and the state enumerations used by the per-slave
// transfer FSMs and the per-master decode-error FSMs.
package cross_bar_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Per-slave transfer FSM: grant -> wait for slave_ack -> one dead cycle.
  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } slv_state_t;

  // Per-master decode-error FSM: error ack cycle, then one dead cycle so the
  // still-high request of the failed transfer is not taken again.
  typedef enum logic [1:0] {
    E_IDLE,
    E_ACK,
    E_DEAD
  } err_state_t;

endpackage

// File: rtl/xbar_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer, one per slave port.
// Ports: clk_i/rst_i (async active-high), req_i[N] requests, advance_i lets the
//   pointer move past the current winner, grant_o[N] one-hot combinational grant.
module xbar_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  // ptr_q is the index that currently has highest priority.
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic             found;

  // Two passes: first requesters at or above the pointer, then the wrapped
  // ones below it. This gives the order ptr..N-1,0..ptr-1.
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_q))) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        ptr_d      = (i == N - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        ptr_d      = (i == N - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    // Pointer only moves when a grant is actually taken.
    if (!advance_i) begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cross_bar_nxm.sv
// N-master x M-slave req/ack crossbar; upper address bits select the slave,
// each slave has its own RR arbiter + IDLE/BUSY/RESP FSM so slaves run concurrently.
// Ports: master_* (req/addr/cmd/wdata in, ack/rdata/err out), slave_* (req/addr/
//   cmd/wdata out, ack/rdata in), clk, reset (async active-high). All outputs registered.
module cross_bar_nxm
  import cross_bar_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          master_req,
  input  logic [N_MASTERS*ADDR_W-1:0]   master_addr,
  input  logic [N_MASTERS-1:0]          master_cmd,
  input  logic [N_MASTERS*DATA_W-1:0]   master_wdata,
  output logic [N_MASTERS-1:0]          master_ack,
  output logic [N_MASTERS*DATA_W-1:0]   master_rdata,
  output logic [N_MASTERS-1:0]          master_err,
  output logic [N_SLAVES-1:0]           slave_req,
  output logic [N_SLAVES*ADDR_W-1:0]    slave_addr,
  output logic [N_SLAVES-1:0]           slave_cmd,
  output logic [N_SLAVES*DATA_W-1:0]    slave_wdata,
  input  logic [N_SLAVES-1:0]           slave_ack,
  input  logic [N_SLAVES*DATA_W-1:0]    slave_rdata
);

  localparam int SEL_W = $clog2(N_SLAVES);

  // ---------------------------------------------------------------------------
  // Per-master address decode and decode-error path
  // ---------------------------------------------------------------------------
  logic [N_MASTERS-1:0][SEL_W-1:0] dec_idx;
  logic [N_MASTERS-1:0]            dec_ok;
  logic [N_MASTERS-1:0]            err_idle;
  logic [N_MASTERS-1:0]            err_fire;

  for (genvar m = 0; m < N_MASTERS; m++) begin : g_mst
    err_state_t err_q;
    err_state_t err_d;

    assign dec_idx[m] = master_addr[m*ADDR_W + ADDR_W - 1 -: SEL_W];
    // Extra bit keeps the compare correct when N_SLAVES is a power of two.
    assign dec_ok[m]  = {1'b0, dec_idx[m]} < (SEL_W + 1)'(N_SLAVES);

    assign err_idle[m] = (err_q == E_IDLE);
    assign err_fire[m] = err_idle[m] & master_req[m] & ~dec_ok[m];

    always_comb begin
      err_d = err_q;
      unique case (err_q)
        E_IDLE:  if (err_fire[m]) err_d = E_ACK;
        E_ACK:   err_d = E_DEAD;
        E_DEAD:  err_d = E_IDLE;
        default: err_d = E_IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        err_q <= E_IDLE;
      end else begin
        err_q <= err_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-slave arbiter, transfer FSM and forwarded-request latches
  // ---------------------------------------------------------------------------
  // slv_fin[s] is the owner one-hot in the cycle slave s completes, else 0.
  logic [N_SLAVES-1:0][N_MASTERS-1:0] slv_fin;
  logic [N_SLAVES-1:0]                slv_cmd;

  for (genvar s = 0; s < N_SLAVES; s++) begin : g_slv
    logic [N_MASTERS-1:0] req_vec;
    logic [N_MASTERS-1:0] grant;
    logic [N_MASTERS-1:0] owner_q, owner_d;
    slv_state_t           state_q, state_d;
    logic                 sreq_q, sreq_d;
    logic                 scmd_q, scmd_d;
    logic [ADDR_W-1:0]    saddr_q, saddr_d;
    logic [DATA_W-1:0]    swd_q, swd_d;

    // A master in its error dead window is hidden from every slave.
    always_comb begin
      req_vec = '0;
      for (int m = 0; m < N_MASTERS; m++) begin
        req_vec[m] = master_req[m] & err_idle[m] & dec_ok[m] &
                     (dec_idx[m] == SEL_W'(s));
      end
    end

    xbar_rr_arbiter #(
      .N (N_MASTERS)
    ) u_arb (
      .clk_i     (clk),
      .rst_i     (reset),
      .req_i     (req_vec),
      .advance_i (state_q == S_IDLE),
      .grant_o   (grant)
    );

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      sreq_d  = sreq_q;
      scmd_d  = scmd_q;
      saddr_d = saddr_q;
      swd_d   = swd_q;
      unique case (state_q)
        S_IDLE: begin
          if (|grant) begin
            owner_d = grant;
            sreq_d  = 1'b1;
            scmd_d  = 1'b0;
            saddr_d = '0;
            swd_d   = '0;
            for (int m = 0; m < N_MASTERS; m++) begin
              if (grant[m]) begin
                scmd_d  = scmd_d  | master_cmd[m];
                saddr_d = saddr_d | master_addr[m*ADDR_W +: ADDR_W];
                swd_d   = swd_d   | master_wdata[m*DATA_W +: DATA_W];
              end
            end
            state_d = S_BUSY;
          end
        end
        S_BUSY: begin
          if (slave_ack[s]) begin
            sreq_d  = 1'b0;
            state_d = S_RESP;
          end
        end
        // Dead cycle: the owner still holds req while it sees its ack.
        S_RESP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= S_IDLE;
        owner_q <= '0;
        sreq_q  <= 1'b0;
        scmd_q  <= 1'b0;
        saddr_q <= '0;
        swd_q   <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        sreq_q  <= sreq_d;
        scmd_q  <= scmd_d;
        saddr_q <= saddr_d;
        swd_q   <= swd_d;
      end
    end

    assign slave_req[s]                    = sreq_q;
    assign slave_cmd[s]                    = scmd_q;
    assign slave_addr[s*ADDR_W +: ADDR_W]  = saddr_q;
    assign slave_wdata[s*DATA_W +: DATA_W] = swd_q;

    // slave_ack outside S_BUSY (slave_req low) never produces a completion.
    assign slv_fin[s] = ((state_q == S_BUSY) && slave_ack[s]) ? owner_q : '0;
    assign slv_cmd[s] = scmd_q;
  end

  // ---------------------------------------------------------------------------
  // Master-side response routing, registered
  // ---------------------------------------------------------------------------
  // Each master owns at most one transfer, so at most one term per master is
  // ever set and the OR-merge cannot collide.
  logic [N_MASTERS-1:0]             mack_d, mack_q;
  logic [N_MASTERS-1:0]             merr_q;
  logic [N_MASTERS-1:0][DATA_W-1:0] mrd_d, mrd_q;

  always_comb begin
    mack_d = err_fire;
    mrd_d  = '0;
    for (int m = 0; m < N_MASTERS; m++) begin
      for (int s = 0; s < N_SLAVES; s++) begin
        if (slv_fin[s][m]) begin
          mack_d[m] = 1'b1;
          if (slv_cmd[s] == CMD_READ) begin
            mrd_d[m] = mrd_d[m] | slave_rdata[s*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mack_q <= '0;
      merr_q <= '0;
      mrd_q  <= '0;
    end else begin
      mack_q <= mack_d;
      merr_q <= err_fire;
      mrd_q  <= mrd_d;
    end
  end

  assign master_ack   = mack_q;
  assign master_err   = merr_q;
  assign master_rdata = mrd_q;

endmodule

// File: tb/tb_cross_bar_nxm.sv
// Directed testbench for cross_bar_nxm: a 2x2 instance for transfer, arbitration,
// slow-slave, spurious-ack and reset cases, and a 2x3 instance for decode errors.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_cross_bar_nxm;
  import cross_bar_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // 2 masters x 2 slaves
  logic [1:0]  a_mreq, a_mcmd, a_mack, a_merr;
  logic [63:0] a_maddr, a_mwdata, a_mrdata;
  logic [1:0]  a_sreq, a_scmd, a_sack;
  logic [63:0] a_saddr, a_swdata, a_srdata;

  // 2 masters x 3 slaves
  logic [1:0]  b_mreq, b_mcmd, b_mack, b_merr;
  logic [63:0] b_maddr, b_mwdata, b_mrdata;
  logic [2:0]  b_sreq, b_scmd, b_sack;
  logic [95:0] b_saddr, b_swdata, b_srdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cross_bar_nxm #(.N_MASTERS(2), .N_SLAVES(2), .ADDR_W(32), .DATA_W(32)) dut_a (
    .clk(clk), .reset(reset),
    .master_req(a_mreq), .master_addr(a_maddr), .master_cmd(a_mcmd),
    .master_wdata(a_mwdata), .master_ack(a_mack), .master_rdata(a_mrdata),
    .master_err(a_merr), .slave_req(a_sreq), .slave_addr(a_saddr),
    .slave_cmd(a_scmd), .slave_wdata(a_swdata), .slave_ack(a_sack),
    .slave_rdata(a_srdata)
  );

  cross_bar_nxm #(.N_MASTERS(2), .N_SLAVES(3), .ADDR_W(32), .DATA_W(32)) dut_b (
    .clk(clk), .reset(reset),
    .master_req(b_mreq), .master_addr(b_maddr), .master_cmd(b_mcmd),
    .master_wdata(b_mwdata), .master_ack(b_mack), .master_rdata(b_mrdata),
    .master_err(b_merr), .slave_req(b_sreq), .slave_addr(b_saddr),
    .slave_cmd(b_scmd), .slave_wdata(b_swdata), .slave_ack(b_sack),
    .slave_rdata(b_srdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_mreq = '0; a_mcmd = '0; a_maddr = '0; a_mwdata = '0; a_sack = '0; a_srdata = '0;
    b_mreq = '0; b_mcmd = '0; b_maddr = '0; b_mwdata = '0; b_sack = '0; b_srdata = '0;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_a_sreq",   64'(a_sreq),   64'd0);
    chk("rst_a_saddr",  64'(a_saddr),  64'd0);
    chk("rst_a_scmd",   64'(a_scmd),   64'd0);
    chk("rst_a_swdata", 64'(a_swdata), 64'd0);
    chk("rst_a_mack",   64'(a_mack),   64'd0);
    chk("rst_a_merr",   64'(a_merr),   64'd0);
    chk("rst_a_mrdata", 64'(a_mrdata), 64'd0);
    chk("rst_b_sreq",   64'(b_sreq),   64'd0);
    chk("rst_b_saddr",  64'(b_saddr[63:0]), 64'd0);
    chk("rst_b_scmd",   64'(b_scmd),   64'd0);
    chk("rst_b_swdata", 64'(b_swdata[63:0]), 64'd0);
    chk("rst_b_mack",   64'(b_mack),   64'd0);
    reset = 1'b0;
    tick();

    // ---------------- parallel: M0 read S0, M1 write S1 ----------------
    a_mreq   = 2'b11;
    a_mcmd   = {CMD_WRITE, CMD_READ};
    a_maddr  = {32'h8000_0020, 32'h0000_0010};
    a_mwdata = {32'h0000_CAFE, 32'h0000_0000};
    tick();  // cycle 1
    chk("par_sreq",     64'(a_sreq),           64'h3);
    chk("par_s0_addr",  64'(a_saddr[31:0]),    64'h10);
    chk("par_s1_addr",  64'(a_saddr[63:32]),   64'h8000_0020);
    chk("par_scmd",     64'(a_scmd),           64'h2);
    chk("par_s1_wdata", 64'(a_swdata[63:32]),  64'hCAFE);
    chk("par_mack_c1",  64'(a_mack),           64'd0);
    a_sack   = 2'b11;
    a_srdata = {32'hDEAD_BEEF, 32'h1234_5678};
    tick();  // cycle 2
    a_sack = '0;
    chk("par_mack",     64'(a_mack),           64'h3);
    chk("par_m0_rdata", 64'(a_mrdata[31:0]),   64'h1234_5678);
    chk("par_m1_rdata", 64'(a_mrdata[63:32]),  64'd0);
    chk("par_merr",     64'(a_merr),           64'd0);
    chk("par_sreq_c2",  64'(a_sreq),           64'd0);
    tick();  // cycle 3: requests were still high in the dead cycle
    chk("par_mack_c3",   64'(a_mack), 64'd0);
    chk("par_no_regrant", 64'(a_sreq), 64'd0);
    a_mreq = '0;
    tick();

    // ---------------- contention on S1: M0,M1,M0,M1 ----------------
    a_mcmd  = {CMD_READ, CMD_READ};
    a_maddr = {32'h8000_0200, 32'h8000_0100};
    a_mreq  = 2'b11;
    tick();
    for (int i = 0; i < 4; i++) begin
      int o;
      logic [31:0] ea;
      o  = i % 2;
      ea = (o == 1) ? 32'h8000_0200 : 32'h8000_0100;
      chk("cnt_sreq",     64'(a_sreq),          64'h2);
      chk("cnt_saddr",    64'(a_saddr[63:32]),  64'(ea));
      chk("cnt_mack_pre", 64'(a_mack),          64'd0);
      a_sack = 2'b10;
      a_srdata[63:32] = 32'hA0 + i;
      tick();
      a_sack = '0;
      chk("cnt_mack",  64'(a_mack), 64'd1 << o);
      chk("cnt_rdata", 64'((o == 1) ? a_mrdata[63:32] : a_mrdata[31:0]), 64'(32'hA0 + i));
      chk("cnt_sreq_resp", 64'(a_sreq), 64'd0);
      if (i == 3) a_mreq = '0;
      tick();
      chk("cnt_dead", 64'(a_sreq), 64'd0);
      tick();
    end
    chk("cnt_idle_sreq", 64'(a_sreq), 64'd0);
    chk("cnt_idle_mack", 64'(a_mack), 64'd0);

    // ---------------- slow slave on S0: ack at cycle 5 ----------------
    a_mcmd  = 2'b00;
    a_maddr = {32'h0, 32'h0000_0044};
    a_mreq  = 2'b01;
    tick();  // cycle 1
    for (int k = 1; k <= 5; k++) begin
      chk("slow_sreq",  64'(a_sreq),         64'h1);
      chk("slow_saddr", 64'(a_saddr[31:0]),  64'h44);
      chk("slow_mack",  64'(a_mack),         64'd0);
      if (k == 5) begin
        a_sack = 2'b01;
        a_srdata = {32'h0, 32'h0000_0077};
      end
      tick();
    end
    a_sack = '0;  // cycle 6
    chk("slow_ack6",   64'(a_mack),          64'h1);
    chk("slow_rdata",  64'(a_mrdata[31:0]),  64'h77);
    chk("slow_sreq6",  64'(a_sreq),          64'd0);
    tick();
    a_mreq = '0;
    chk("slow_done", 64'(a_mack), 64'd0);
    tick();

    // ---------------- spurious slave_ack while idle ----------------
    a_sack   = 2'b11;
    a_srdata = {32'h1111_1111, 32'h2222_2222};
    tick();
    a_sack = '0;
    chk("spur_mack", 64'(a_mack), 64'd0);
    chk("spur_sreq", 64'(a_sreq), 64'd0);
    chk("spur_merr", 64'(a_merr), 64'd0);
    a_maddr = {32'h0000_0008, 32'h0};
    a_mreq  = 2'b10;
    tick();
    chk("spur_next_sreq",  64'(a_sreq),        64'h1);
    chk("spur_next_saddr", 64'(a_saddr[31:0]), 64'h8);
    a_sack   = 2'b01;
    a_srdata = {32'h0, 32'h0000_003C};
    tick();
    a_sack = '0;
    chk("spur_next_mack",  64'(a_mack),          64'h2);
    chk("spur_next_rdata", 64'(a_mrdata[63:32]), 64'h3C);
    tick();
    a_mreq = '0;
    tick();

    // ---------------- decode error on the 3-slave instance ----------------
    b_mcmd  = 2'b00;
    b_maddr = {32'h0, 32'hC000_0000};
    b_mreq  = 2'b01;
    tick();  // cycle 1
    chk("dec_mack",   64'(b_mack),   64'h1);
    chk("dec_merr",   64'(b_merr),   64'h1);
    chk("dec_mrdata", 64'(b_mrdata), 64'd0);
    chk("dec_sreq",   64'(b_sreq),   64'd0);
    tick();  // cycle 2: new valid request to S2 must wait one more cycle
    chk("dec_mack_c2", 64'(b_mack), 64'd0);
    chk("dec_merr_c2", 64'(b_merr), 64'd0);
    b_maddr = {32'h0, 32'h8000_0004};
    tick();  // cycle 3
    chk("dec_not_early", 64'(b_sreq), 64'd0);
    tick();  // cycle 4
    chk("dec_next_sreq",  64'(b_sreq),          64'h4);
    chk("dec_next_saddr", 64'(b_saddr[95:64]),  64'h8000_0004);
    b_sack = 3'b100;
    b_srdata = {32'h0000_0099, 64'h0};
    tick();
    b_sack = '0;
    chk("dec_next_mack",  64'(b_mack),         64'h1);
    chk("dec_next_merr",  64'(b_merr),         64'd0);
    chk("dec_next_rdata", 64'(b_mrdata[31:0]), 64'h99);
    b_mreq = '0;
    tick();

    // ---------------- reset in the middle of S_BUSY ----------------
    a_maddr = {32'h0, 32'h0000_000C};
    a_mreq  = 2'b01;
    tick();
    chk("rbusy_sreq", 64'(a_sreq), 64'h1);
    reset = 1'b1;
    #1;
    chk("rbusy_async_sreq", 64'(a_sreq), 64'd0);
    a_mreq = '0;
    tick();
    chk("rbusy_sreq_edge",  64'(a_sreq),         64'd0);
    chk("rbusy_saddr_edge", 64'(a_saddr[31:0]),  64'd0);
    chk("rbusy_mack_edge",  64'(a_mack),         64'd0);
    tick();
    reset  = 1'b0;
    a_sack = 2'b01;
    a_srdata = {32'h0, 32'h0000_0005};
    tick();
    a_sack = '0;
    chk("rbusy_no_ack1", 64'(a_mack), 64'd0);
    chk("rbusy_no_sreq", 64'(a_sreq), 64'd0);
    tick();
    chk("rbusy_no_ack2", 64'(a_mack), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
